// File: rtl/sdram_defs.sv
// Shared SDRAM command/address definitions: command encodings, access sizes,
// burst-length codes and address-mode codes used by the bus-side blocks.
package sdram_defs;

  // Command bus encodings (111 decodes as a second NOP)
  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_ACT  = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [2:0] CMD_WR   = 3'b011;
  localparam logic [2:0] CMD_PRE  = 3'b100;
  localparam logic [2:0] CMD_LMR  = 3'b101;
  localparam logic [2:0] CMD_BST  = 3'b110;
  localparam logic [2:0] CMD_NOP2 = 3'b111;

  // Access size; the column step is 1 << size
  localparam logic [1:0] SIZE_B  = 2'd0;
  localparam logic [1:0] SIZE_HW = 2'd1;
  localparam logic [1:0] SIZE_W  = 2'd2;
  localparam logic [1:0] SIZE_DW = 2'd3;

  // Burst length codes; beats = 1 << code, except PAGE which never ends by itself
  localparam logic [2:0] BURST1     = 3'd0;
  localparam logic [2:0] BURST2     = 3'd1;
  localparam logic [2:0] BURST4     = 3'd2;
  localparam logic [2:0] BURST8     = 3'd3;
  localparam logic [2:0] BURST16    = 3'd4;
  localparam logic [2:0] BURST32    = 3'd5;
  localparam logic [2:0] BURST64    = 3'd6;
  localparam logic [2:0] BURST_PAGE = 3'd7;

  // Column wrap behaviour
  localparam logic ADDR_MODE_SEQ = 1'b0;
  localparam logic ADDR_MODE_LIN = 1'b1;

  // Mode register contents loaded by LMR
  typedef struct packed {
    logic [2:0] bl_cfg;
    logic       addr_mode;
  } mode_reg_t;

  localparam mode_reg_t MODE_RESET = '{bl_cfg: BURST1, addr_mode: ADDR_MODE_SEQ};

endpackage

// File: rtl/sdram_burst_col_counter.sv
// Column sequencer for one SDRAM burst. A load captures start column, step,
// burst length and wrap mode; each adv moves to the next beat. Sequential mode
// wraps inside the aligned block of min(BL*step, 2^ADDR_W) columns, linear mode
// wraps over the whole row. 'last' flags the final beat (never in page mode).
module sdram_burst_col_counter
  import sdram_defs::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [ADDR_W-1:0] start_col,
  input  logic [1:0]        size,
  input  mode_reg_t         mode,
  output logic [ADDR_W-1:0] col,
  output logic              last
);

  localparam logic [ADDR_W:0]   ONE_WIDE = 1;
  localparam logic [ADDR_W-1:0] ONE_COL  = 1;

  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] mask_q, mask_d;
  logic [6:0]        beat_q, beat_d;
  logic [6:0]        last_beat_q, last_beat_d;
  logic              page_q, page_d;
  logic              lin_q, lin_d;

  logic [3:0]        log_blk;
  logic [ADDR_W:0]   blk_size;
  logic [ADDR_W:0]   blk_mask_wide;
  logic [ADDR_W-1:0] col_sum;

  // Burst geometry for the command being loaded, and next-beat column arithmetic
  always_comb begin
    log_blk = {1'b0, mode.bl_cfg} + {2'b00, size};
    if (mode.bl_cfg == BURST_PAGE || int'(log_blk) > ADDR_W) begin
      log_blk = 4'(ADDR_W);
    end
    blk_size      = ONE_WIDE << log_blk;
    blk_mask_wide = blk_size - ONE_WIDE;
    col_sum       = col_q + step_q;

    col_d       = col_q;
    step_d      = step_q;
    mask_d      = mask_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    page_d      = page_q;
    lin_d       = lin_q;

    if (load) begin
      col_d       = start_col;
      step_d      = ONE_COL << size;
      mask_d      = blk_mask_wide[ADDR_W-1:0];
      beat_d      = 7'd0;
      last_beat_d = (7'd1 << mode.bl_cfg) - 7'd1;
      page_d      = (mode.bl_cfg == BURST_PAGE);
      lin_d       = (mode.addr_mode == ADDR_MODE_LIN);
    end else if (adv) begin
      // Sequential mode keeps the block base bits and wraps only the offset
      col_d  = lin_q ? col_sum : ((col_q & ~mask_q) | (col_sum & mask_q));
      beat_d = beat_q + 7'd1;
    end
  end

  // Burst state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      step_q      <= ONE_COL;
      mask_q      <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      page_q      <= 1'b0;
      lin_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      step_q      <= step_d;
      mask_q      <= mask_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      page_q      <= page_d;
      lin_q       <= lin_d;
    end
  end

  assign col  = col_q;
  assign last = !page_q && (beat_q == last_beat_q);

endmodule

// File: rtl/sdram_burst_responder.sv
// Device-side SDRAM command responder: decodes bus commands, tracks the open
// row and mode register, sequences column bursts through the column counter,
// and delays read strobes by CAS_LAT cycles into RdDataValid.
module sdram_burst_responder
  import sdram_defs::*;
#(
  parameter int CAS_LAT = 2,
  parameter int ADDR_W  = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cke,
  input  logic [2:0]        Cmd,
  input  logic [ADDR_W-1:0] AddrBus,
  input  logic [1:0]        SizeIn,
  output logic [ADDR_W-1:0] ArrayRowAddr,
  output logic [ADDR_W-1:0] ArrayColAddr,
  output logic              ArrayWr,
  output logic              ArrayRd,
  output logic              RdDataValid,
  output logic              RowOpen,
  output logic              BurstDone,
  output logic              CmdError
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RD     = 2'd2;
  localparam logic [1:0] ST_WR     = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  row_q, row_d;
  mode_reg_t          mode_q, mode_d;
  logic               err_q, err_d;
  logic [CAS_LAT-1:0] rd_pipe_q, rd_pipe_d, rd_pipe_in;

  logic               col_load, col_adv, col_last;
  logic [ADDR_W-1:0]  col;
  logic               bursting;
  logic               burst_cut;

  sdram_burst_col_counter #(.ADDR_W(ADDR_W)) u_col_counter (
    .clk       (Clk),
    .rst       (Rst),
    .load      (col_load),
    .adv       (col_adv),
    .start_col (AddrBus),
    .size      (SizeIn),
    .mode      (mode_q),
    .col       (col),
    .last      (col_last)
  );

  assign bursting  = (state_q == ST_RD) || (state_q == ST_WR);
  // Commands that end the current burst early, suppressing its done pulse
  assign burst_cut = (Cmd == CMD_RD) || (Cmd == CMD_WR) || (Cmd == CMD_BST) || (Cmd == CMD_PRE);

  // Command decode and FSM; nothing moves while Cke is low
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    mode_d   = mode_q;
    err_d    = 1'b0;
    col_load = 1'b0;
    col_adv  = 1'b0;
    if (Cke) begin
      case (state_q)
        ST_IDLE: begin
          case (Cmd)
            CMD_ACT: begin
              state_d = ST_ACTIVE;
              row_d   = AddrBus;
            end
            CMD_LMR: begin
              mode_d.bl_cfg    = AddrBus[2:0];
              mode_d.addr_mode = AddrBus[3];
            end
            CMD_RD, CMD_WR, CMD_BST, CMD_PRE: err_d = 1'b1;
            default: ;
          endcase
        end
        ST_ACTIVE: begin
          case (Cmd)
            CMD_RD: begin
              state_d  = ST_RD;
              col_load = 1'b1;
            end
            CMD_WR: begin
              state_d  = ST_WR;
              col_load = 1'b1;
            end
            CMD_PRE: state_d = ST_IDLE;
            CMD_ACT, CMD_LMR: err_d = 1'b1;
            default: ;
          endcase
        end
        default: begin
          case (Cmd)
            CMD_RD: begin
              state_d  = ST_RD;
              col_load = 1'b1;
            end
            CMD_WR: begin
              state_d  = ST_WR;
              col_load = 1'b1;
            end
            CMD_BST: state_d = ST_ACTIVE;
            CMD_PRE: state_d = ST_IDLE;
            default: begin
              // ACT/LMR are rejected but the burst keeps running
              err_d = (Cmd == CMD_ACT) || (Cmd == CMD_LMR);
              if (col_last) begin
                state_d = ST_ACTIVE;
              end else begin
                col_adv = 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      mode_q  <= MODE_RESET;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Read-valid delay line: stage 0 takes the read strobe, later stages shift
  genvar gi;
  generate
    for (gi = 0; gi < CAS_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign rd_pipe_in[gi] = ArrayRd;
      end else begin : g_tail
        assign rd_pipe_in[gi] = rd_pipe_q[gi-1];
      end
    end
  endgenerate

  // Delay line only advances on enabled clocks so in-flight reads survive Cke low
  always_comb begin
    rd_pipe_d = Cke ? rd_pipe_in : rd_pipe_q;
  end

  // Read-valid delay line registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q <= rd_pipe_d;
    end
  end

  assign ArrayRd      = Cke && (state_q == ST_RD);
  assign ArrayWr      = Cke && (state_q == ST_WR);
  assign BurstDone    = Cke && bursting && col_last && !burst_cut;
  assign RowOpen      = (state_q != ST_IDLE);
  assign ArrayRowAddr = row_q;
  assign ArrayColAddr = col;
  assign CmdError     = err_q;
  assign RdDataValid  = rd_pipe_q[CAS_LAT-1];

endmodule
